// File: rtl/bcd_increment_arbiter.sv
// Shares one BCD counter between several increment sources. Each source's
// increment pulses are queued in a saturating pending counter, and sources are
// served round-robin through the counter's enable/ready handshake. Only one
// increment is in flight at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_SELECT  | idle; pick the next source with pending work when ready=1
// S_ASSERT  | enable held high until the counter drops ready (accepted)
// S_RELEASE | enable low; wait for ready to return (countValue updated)
module bcd_increment_arbiter #(
    parameter int NUM_REQUESTERS   = 4,
    parameter int PENDING_BITWIDTH = 4,
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int TIMEOUT_BITWIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] incRequest,
    input  logic                      clearErrors,
    input  logic                      counterReady,
    output logic                      counterEnable,
    output logic [NUM_REQUESTERS-1:0] grantDone,
    output logic [NUM_REQUESTERS-1:0] pendingOverflow,
    output logic                      timeoutError,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [PENDING_BITWIDTH-1:0] PEND_MAX = '1;
    localparam logic [TIMEOUT_BITWIDTH-1:0] TMO_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SELECT,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            winner;
    logic [IDX_W-1:0]            rr_ptr;
    logic [TIMEOUT_BITWIDTH-1:0] tmo_cnt;
    logic [PENDING_BITWIDTH-1:0] pending [NUM_REQUESTERS];

    logic [NUM_REQUESTERS-1:0]   pend_nz;
    logic [NUM_REQUESTERS-1:0]   winner_vec;
    logic [NUM_REQUESTERS-1:0]   dec_vec;
    logic [NUM_REQUESTERS-1:0]   ovf_set;
    logic                        complete;
    logic                        pick_found;
    logic [IDX_W-1:0]            pick_idx;
    logic [IDX_W:0]              scan_sum;
    logic [IDX_W-1:0]            scan_idx;
    logic [IDX_W-1:0]            rr_next;

    // A completion is the counter raising ready again while we wait in RELEASE.
    assign complete = (state == S_RELEASE) && counterReady;
    assign rr_next  = (winner == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : winner + IDX_W'(1);
    assign busy     = (state != S_SELECT) || (|pend_nz);

    // Per-source status: nonzero pending, decrement and overflow conditions.
    always_comb begin
        pend_nz    = '0;
        winner_vec = '0;
        dec_vec    = '0;
        ovf_set    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            pend_nz[i]    = (pending[i] != '0);
            winner_vec[i] = (winner == IDX_W'(i));
            dec_vec[i]    = complete && winner_vec[i];
            // A completion in the same cycle frees a slot, so no drop then.
            ovf_set[i]    = incRequest[i] && !dec_vec[i] && (pending[i] == PEND_MAX);
        end
    end

    // Round-robin scan starting at rr_ptr, wrapping, first nonzero pending wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (scan_sum >= (IDX_W + 1)'(NUM_REQUESTERS)) begin
                scan_sum = scan_sum - (IDX_W + 1)'(NUM_REQUESTERS);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!pick_found && pend_nz[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Saturating pending counters; request and completion together cancel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (incRequest[i] && !dec_vec[i]) begin
                    if (pending[i] != PEND_MAX) begin
                        pending[i] <= pending[i] + PENDING_BITWIDTH'(1);
                    end
                end else if (!incRequest[i] && dec_vec[i]) begin
                    pending[i] <= pending[i] - PENDING_BITWIDTH'(1);
                end
            end
        end
    end

    // Sticky overflow flags; a flag being set this cycle wins over clearErrors.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendingOverflow <= '0;
        end else begin
            pendingOverflow <= ovf_set | (pendingOverflow & {NUM_REQUESTERS{!clearErrors}});
        end
    end

    // Handshake sequencer: one increment at a time, bounded wait on each ready edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_SELECT;
            winner        <= '0;
            rr_ptr        <= '0;
            tmo_cnt       <= '0;
            counterEnable <= 1'b0;
            grantDone     <= '0;
            timeoutError  <= 1'b0;
        end else begin
            grantDone <= '0;
            if (clearErrors) begin
                timeoutError <= 1'b0;
            end
            case (state)
                S_SELECT: begin
                    counterEnable <= 1'b0;
                    if (counterReady && pick_found) begin
                        winner        <= pick_idx;
                        tmo_cnt       <= '0;
                        counterEnable <= 1'b1;
                        state         <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (!counterReady) begin
                        tmo_cnt       <= '0;
                        counterEnable <= 1'b0;
                        state         <= S_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort without touching pending or rr_ptr so the same source retries.
                        tmo_cnt       <= '0;
                        timeoutError  <= 1'b1;
                        counterEnable <= 1'b0;
                        state         <= S_SELECT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_BITWIDTH'(1);
                    end
                end
                S_RELEASE: begin
                    counterEnable <= 1'b0;
                    if (counterReady) begin
                        grantDone <= winner_vec;
                        rr_ptr    <= rr_next;
                        state     <= S_SELECT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt      <= '0;
                        timeoutError <= 1'b1;
                        state        <= S_SELECT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_BITWIDTH'(1);
                    end
                end
                default: begin
                    counterEnable <= 1'b0;
                    state         <= S_SELECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_increment_arbiter.sv
// Directed bench for bcd_increment_arbiter with a behavioural model of the
// shared counter (enable/ready handshake, increments a count when done).
module tb_bcd_increment_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] incRequest = '0;
    logic       clearErrors = 1'b0;
    logic       counterReady;
    logic       counterEnable;
    logic [3:0] grantDone;
    logic [3:0] pendingOverflow;
    logic       timeoutError;
    logic       busy;

    // counter model: 0 normal, 1 held not ready, 2 ready stuck high, 3 manual
    int   mode = 0;
    logic man_ready = 1'b1;
    logic model_ready = 1'b1;
    int   dly = 0;
    int   count_value = 0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   grant_log[$];
    bit   multi_grant = 1'b0;

    bcd_increment_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .incRequest     (incRequest),
        .clearErrors    (clearErrors),
        .counterReady   (counterReady),
        .counterEnable  (counterEnable),
        .grantDone      (grantDone),
        .pendingOverflow(pendingOverflow),
        .timeoutError   (timeoutError),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    assign counterReady = (mode == 3) ? man_ready :
                          (mode == 1) ? 1'b0 :
                          (mode == 2) ? 1'b1 : model_ready;

    // Counter model: accept on enable while ready, finish after a short delay.
    always @(posedge clock) begin
        if (mode == 0) begin
            if (model_ready) begin
                if (counterEnable) begin
                    model_ready <= 1'b0;
                    dly <= 2;
                end
            end else if (dly == 0) begin
                count_value <= count_value + 1;
                model_ready <= 1'b1;
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Grant logger.
    always @(negedge clock) begin
        if (grantDone != 4'b0000) begin
            if (!$onehot(grantDone)) multi_grant = 1'b1;
            for (int i = 0; i < 4; i++) if (grantDone[i]) grant_log.push_back(i);
        end
    end

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_enable(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clock);
            if (counterEnable) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        incRequest = '0;
        clearErrors = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({counterEnable, grantDone, pendingOverflow, timeoutError, busy} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b gd=%b ovf=%b to=%b busy=%b, want all 0",
                     counterEnable, grantDone, pendingOverflow, timeoutError, busy);
        end
        reset = 1'b1;
        @(negedge clock);
        grant_log.delete();
        multi_grant = 1'b0;
    endtask

    task automatic test_single();
        int c0;
        bit ok;
        mode = 0;
        test_reset();
        c0 = count_value;
        incRequest = 4'b0001;
        @(negedge clock);
        incRequest = 4'b0000;
        n_checks++;
        if (counterEnable !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cycle1: en=%b busy=%b, want en=0 busy=1", counterEnable, busy);
        end
        @(negedge clock);
        n_checks++;
        if (counterEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cycle2_enable: en=%b, want 1", counterEnable);
        end
        wait_idle(100, ok);
        @(negedge clock);
        n_checks++;
        if (!ok || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: ok=%0d busy=%b, want idle", ok, busy);
        end
        n_checks++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            n_fail++;
            $display("FAIL single_grant: %0d grants (first %0d), want one grant to 0",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
        n_checks++;
        if (count_value - c0 != 1) begin
            n_fail++;
            $display("FAIL single_count: count=%0d, want 1", count_value - c0);
        end
    endtask

    task automatic test_round_robin();
        int c0;
        bit ok;
        mode = 0;
        test_reset();
        c0 = count_value;
        repeat (3) begin
            incRequest = 4'b1111;
            @(negedge clock);
        end
        incRequest = 4'b0000;
        wait_idle(500, ok);
        @(negedge clock);
        n_checks++;
        if (!ok || grant_log.size() != 12) begin
            n_fail++;
            $display("FAIL rr_grant_count: ok=%0d grants=%0d, want 12", ok, grant_log.size());
        end
        for (int i = 0; i < grant_log.size() && i < 12; i++) begin
            n_checks++;
            if (grant_log[i] != i % 4) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: source %0d, want %0d", i, grant_log[i], i % 4);
            end
        end
        n_checks++;
        if (count_value - c0 != 12 || pendingOverflow !== 4'b0000 || multi_grant) begin
            n_fail++;
            $display("FAIL rr_final: count=%0d ovf=%b multi=%0d, want 12 0000 0",
                     count_value - c0, pendingOverflow, multi_grant);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int n2;
        mode = 1;
        test_reset();
        repeat (17) begin
            incRequest = 4'b0100;
            @(negedge clock);
        end
        incRequest = 4'b0000;
        @(negedge clock);
        n_checks++;
        if (pendingOverflow !== 4'b0100 || busy !== 1'b1 || grant_log.size() != 0) begin
            n_fail++;
            $display("FAIL sat_overflow: ovf=%b busy=%b grants=%0d, want 0100 1 0",
                     pendingOverflow, busy, grant_log.size());
        end
        mode = 0;
        wait_idle(1000, ok);
        @(negedge clock);
        n2 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 2) n2++;
        n_checks++;
        if (!ok || n2 != 15 || grant_log.size() != 15) begin
            n_fail++;
            $display("FAIL sat_grants: ok=%0d src2=%0d total=%0d, want 15", ok, n2, grant_log.size());
        end
        n_checks++;
        if (pendingOverflow !== 4'b0100) begin
            n_fail++;
            $display("FAIL sat_sticky: ovf=%b, want 0100", pendingOverflow);
        end
        clearErrors = 1'b1;
        @(negedge clock);
        clearErrors = 1'b0;
        n_checks++;
        if (pendingOverflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat_clear: ovf=%b, want 0000", pendingOverflow);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int en;
        int c0;
        mode = 2;
        test_reset();
        c0 = count_value;
        incRequest = 4'b1000;
        @(negedge clock);
        incRequest = 4'b0000;
        ok = 1'b0;
        en = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (timeoutError) begin
                ok = 1'b1;
                break;
            end
            if (counterEnable) en++;
        end
        n_checks++;
        if (!ok || en != 64) begin
            n_fail++;
            $display("FAIL to_cycles: seen=%0d enable_cycles=%0d, want 1 64", ok, en);
        end
        n_checks++;
        if (counterEnable !== 1'b0 || busy !== 1'b1 || grant_log.size() != 0) begin
            n_fail++;
            $display("FAIL to_state: en=%b busy=%b grants=%0d, want 0 1 0",
                     counterEnable, busy, grant_log.size());
        end
        mode = 0;
        wait_idle(200, ok);
        @(negedge clock);
        n_checks++;
        if (!ok || grant_log.size() != 1 || grant_log[0] != 3 || count_value - c0 != 1) begin
            n_fail++;
            $display("FAIL to_retry: ok=%0d grants=%0d count=%0d, want one grant to 3",
                     ok, grant_log.size(), count_value - c0);
        end
        n_checks++;
        if (timeoutError !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky: timeoutError=%b, want 1", timeoutError);
        end
        clearErrors = 1'b1;
        @(negedge clock);
        clearErrors = 1'b0;
        n_checks++;
        if (timeoutError !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: timeoutError=%b, want 0", timeoutError);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        mode = 3;
        man_ready = 1'b1;
        test_reset();
        incRequest = 4'b0010;
        @(negedge clock);
        incRequest = 4'b0000;
        wait_enable(10, ok);
        man_ready = 1'b0;
        @(negedge clock);
        man_ready = 1'b1;
        incRequest = 4'b0010;
        @(negedge clock);
        incRequest = 4'b0000;
        n_checks++;
        if (!ok || grantDone !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: ok=%0d gd=%b busy=%b, want 0010 1", ok, grantDone, busy);
        end
        @(negedge clock);
        n_checks++;
        if (counterEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_enable: en=%b, want 1", counterEnable);
        end
        man_ready = 1'b0;
        @(negedge clock);
        man_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (grantDone !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_second_grant: gd=%b, want 0010", grantDone);
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || grant_log.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b grants=%0d, want 0 2", busy, grant_log.size());
        end
    endtask

    task automatic test_reset_mid_release();
        bit ok;
        mode = 3;
        man_ready = 1'b1;
        test_reset();
        incRequest = 4'b0001;
        @(negedge clock);
        incRequest = 4'b0000;
        wait_enable(10, ok);
        man_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (!ok || busy !== 1'b1 || counterEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: ok=%0d busy=%b en=%b, want 1 1 0", ok, busy, counterEnable);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({counterEnable, grantDone, pendingOverflow, timeoutError, busy} !== 11'b0) begin
            n_fail++;
            $display("FAIL rst_async: en=%b gd=%b ovf=%b to=%b busy=%b, want all 0",
                     counterEnable, grantDone, pendingOverflow, timeoutError, busy);
        end
        @(negedge clock);
        reset = 1'b1;
        man_ready = 1'b1;
        repeat (10) @(negedge clock);
        n_checks++;
        if (grant_log.size() != 0 || busy !== 1'b0 || counterEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: grants=%0d busy=%b en=%b, want 0 0 0",
                     grant_log.size(), busy, counterEnable);
        end
        mode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_timeout();
        test_back_to_back();
        test_reset_mid_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
